// File: rtl/rsr_pkg.sv
// Shared types and helpers for the result-shift-register array: slot layout,
// latency-field sizing and the legality check for a requested execute latency.
package rsr_pkg;

    localparam int SIZE_PHYSICAL_LOG = 7;

    typedef logic [SIZE_PHYSICAL_LOG-1:0] reg_id_t;

    typedef struct packed {
        logic    valid;
        reg_id_t reg_id;
    } phys_reg;

    // A slot carries exactly what is eventually broadcast, so it shares the layout.
    typedef phys_reg rsr_slot_t;

    function automatic int lat_width(input int max_lat);
        return $clog2(max_lat + 1);
    endfunction

    function automatic logic lat_illegal(input int unsigned lat, input int unsigned max_lat);
        return (lat == 0) || (lat > max_lat);
    endfunction

endpackage

// File: rtl/rsr_lane_slots.sv
// One lane of the result shift register: shifting slot array, latency-indexed
// deposit, collision mask and registered dropped-grant flag.
module rsr_lane_slots
    import rsr_pkg::*;
#(
    parameter int MAX_LATENCY = 4,
    parameter int LAT_W       = lat_width(MAX_LATENCY)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   grant_valid_i,
    input  reg_id_t                grant_tag_i,
    input  logic [LAT_W-1:0]       grant_lat_i,
    input  logic                   freeze_i,
    input  logic                   flush_i,
    output rsr_slot_t              head_o,
    output logic [MAX_LATENCY-1:0] slot_busy_o,
    output logic                   grant_err_o
);

    rsr_slot_t [MAX_LATENCY-1:0] slots_q;
    rsr_slot_t [MAX_LATENCY-1:0] slots_d;
    logic                        err_q;
    logic                        err_d;
    logic                        collide;
    logic                        grant_ok;

    // A latency-L grant lands in S[L-1] after the shift, i.e. where S[L] is heading.
    always_comb begin
        slot_busy_o = '0;
        for (int l = 0; l < MAX_LATENCY - 1; l++) begin
            slot_busy_o[l] = slots_q[l + 1].valid;
        end
    end

    always_comb begin
        collide = 1'b0;
        for (int l = 1; l <= MAX_LATENCY; l++) begin
            if (grant_lat_i == LAT_W'(l)) begin
                collide = slot_busy_o[l - 1];
            end
        end
        grant_ok = grant_valid_i && !lat_illegal(32'(grant_lat_i), MAX_LATENCY) && !collide;

        slots_d = slots_q;
        err_d   = 1'b0;
        if (flush_i) begin
            slots_d = '0;
        end else if (!freeze_i) begin
            for (int k = 0; k < MAX_LATENCY - 1; k++) begin
                slots_d[k] = slots_q[k + 1];
            end
            slots_d[MAX_LATENCY - 1] = '0;
            for (int l = 1; l <= MAX_LATENCY; l++) begin
                if (grant_ok && (grant_lat_i == LAT_W'(l))) begin
                    slots_d[l - 1] = '{valid: 1'b1, reg_id: grant_tag_i};
                end
            end
            err_d = grant_valid_i && !grant_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slots_q <= '0;
            err_q   <= 1'b0;
        end else begin
            slots_q <= slots_d;
            err_q   <= err_d;
        end
    end

    assign head_o      = slots_q[0];
    assign grant_err_o = err_q;

endmodule

// File: rtl/rsr_multi_lane.sv
// Issue-stage wakeup delay array: NUM_LANES independent slot lanes sharing
// freeze, flush and reset.
module rsr_multi_lane
    import rsr_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int MAX_LATENCY = 4,
    parameter int TAG_W       = SIZE_PHYSICAL_LOG,
    parameter int LAT_W       = lat_width(MAX_LATENCY)
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_LANES-1:0]                  grantValid_i,
    input  logic [NUM_LANES-1:0][TAG_W-1:0]       grantTag_i,
    input  logic [NUM_LANES-1:0][LAT_W-1:0]       grantLat_i,
    input  logic                                  freeze_i,
    input  logic                                  flush_i,
    output logic [NUM_LANES-1:0][TAG_W:0]         rsrTag_o,
    output logic [NUM_LANES-1:0][MAX_LATENCY-1:0] slotBusy_o,
    output logic [NUM_LANES-1:0]                  grantErr_o
);

    phys_reg [NUM_LANES-1:0] lane_head;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        rsr_lane_slots #(
            .MAX_LATENCY (MAX_LATENCY),
            .LAT_W       (LAT_W)
        ) u_slots (
            .clk           (clk),
            .reset_n       (reset_n),
            .grant_valid_i (grantValid_i[g]),
            .grant_tag_i   (reg_id_t'(grantTag_i[g])),
            .grant_lat_i   (grantLat_i[g]),
            .freeze_i      (freeze_i),
            .flush_i       (flush_i),
            .head_o        (lane_head[g]),
            .slot_busy_o   (slotBusy_o[g]),
            .grant_err_o   (grantErr_o[g])
        );

        assign rsrTag_o[g] = {lane_head[g].valid, TAG_W'(lane_head[g].reg_id)};
    end

endmodule
